id_ex_stage: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/load_use_hazard.sv | 44 ++++
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage MIPS pipeline control bundles.
//   - Bundle widths for the WB, M and EX control groups.
//   - Bit positions of each control signal inside its bundle.
//   - Primary opcode constants used by the decoder.
//   - uses_rt(): whether an ID instruction reads rt as a source operand.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  // WB bundle {RegWrite, MemtoReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // M bundle {Branch, MemRead, MemWrite}
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // EX bundle {RegDst, ALUSrc, ALUOp[1:0]}
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUSRC   = 2;
  localparam int EX_ALUOP_HI = 1;
  localparam int EX_ALUOP_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  // rt is a source for R-type (RegDst), stores (MemWrite) and branches.
  function automatic logic uses_rt(input logic [M_W-1:0]  m,
                                   input logic [EX_W-1:0] ex);
    return ex[EX_REGDST] | m[M_MEMWRITE] | m[M_BRANCH];
  endfunction

endpackage

// File: rtl/load_use_hazard.sv
// ---------------------------------------------------------------------------
// load_use_hazard
// Purely combinational load-use hazard detector.
// Ports:
//   ex_valid, ex_memread, ex_rt : instruction currently in EX (a load?)
//   id_valid, id_uses_rt, id_rs, id_rt : instruction currently in ID
//   flush       : branch taken, ID instruction is being killed
//   stall       : insert one bubble into EX
//   pc_write    : PC write enable (low while stalling)
//   if_id_write : IF/ID write enable (low while stalling)
// ---------------------------------------------------------------------------
module load_use_hazard #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              flush,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write
);

  logic w_load_use;
  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (ex_rt == id_rs);
  assign w_rt_match = id_uses_rt & (ex_rt == id_rt);

  // A load into $zero never produces a value worth waiting for.
  assign w_load_use = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
                      (w_rs_match | w_rt_match);

  // The ID instruction is dead on a flush, so let the PC take the target.
  assign stall       = w_load_use & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection.
// Ports:
//   clk, reset          : clock; asynchronous active-high reset
//   id_wb/id_m/id_ex    : decoder control bundles (2/3/4 bits)
//   id_valid            : IF/ID holds a real instruction
//   id_pc4, id_rd1, id_rd2, id_imm : ID data operands
//   id_rs, id_rt, id_rd : register specifiers
//   flush               : branch taken, kill the instruction entering EX
//   ex_*                : registered copies for the EX stage
//   stall, pc_write, if_id_write : combinational hazard outputs
// Optional build macro ID_EX_PERF_CNT_EN adds saturating 32-bit
// bubble_cnt (cycles with stall) and flush_cnt (cycles with flush).
// ---------------------------------------------------------------------------
module id_ex_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WB_W-1:0]   id_wb,
  input  logic [M_W-1:0]    id_m,
  input  logic [EX_W-1:0]   id_ex,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic [WB_W-1:0]   ex_wb,
  output logic [M_W-1:0]    ex_m,
  output logic [EX_W-1:0]   ex_ex,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic [WB_W-1:0]   r_wb;
  logic [M_W-1:0]    r_m;
  logic [EX_W-1:0]   r_ex;
  logic              r_valid;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;

  logic w_id_uses_rt;
  logic w_stall;
  logic w_kill;

  assign w_id_uses_rt = uses_rt(id_m, id_ex);

  load_use_hazard #(
    .REG_AW (REG_AW)
  ) u_load_use_hazard (
    .ex_valid    (r_valid),
    .ex_memread  (r_m[M_MEMREAD]),
    .ex_rt       (r_rt),
    .id_valid    (id_valid),
    .id_uses_rt  (w_id_uses_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .flush       (flush),
    .stall       (w_stall),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  // Flush and stall both turn the EX slot into a bubble.
  assign w_kill = flush | w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb    <= '0;
      r_m     <= '0;
      r_ex    <= '0;
      r_valid <= 1'b0;
      r_pc4   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else begin
      // Operands are harmless in a bubble, so they load unconditionally.
      r_pc4 <= id_pc4;
      r_rd1 <= id_rd1;
      r_rd2 <= id_rd2;
      r_imm <= id_imm;
      r_rs  <= id_rs;
      r_rt  <= id_rt;
      r_rd  <= id_rd;
      if (w_kill) begin
        r_wb    <= '0;
        r_m     <= '0;
        r_ex    <= '0;
        r_valid <= 1'b0;
      end else begin
        r_wb    <= id_wb;
        r_m     <= id_m;
        r_ex    <= id_ex;
        r_valid <= id_valid;
      end
    end
  end

  assign ex_wb    = r_wb;
  assign ex_m     = r_m;
  assign ex_ex    = r_ex;
  assign ex_valid = r_valid;
  assign ex_pc4   = r_pc4;
  assign ex_rd1   = r_rd1;
  assign ex_rd2   = r_rd2;
  assign ex_imm   = r_imm;
  assign ex_rs    = r_rs;
  assign ex_rt    = r_rt;
  assign ex_rd    = r_rd;
  assign stall    = w_stall;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_stall && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: a table of directed ID-stage inputs
// with hand-computed stall and EX-stage results, applied in order (state
// carries from one row to the next), plus a reset-during-stall sequence.
// Honours ID_EX_PERF_CNT_EN to check the bubble/flush counters.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  id_wb = '0;
  logic [2:0]  id_m = '0;
  logic [3:0]  id_ex = '0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc4 = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        flush = 1'b0;
  logic [1:0]  ex_wb;
  logic [2:0]  ex_m;
  logic [3:0]  ex_ex;
  logic        ex_valid;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        stall, pc_write, if_id_write;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_valid(id_valid),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex), .ex_valid(ex_valid),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       fl;
    logic       e_stall;
    logic [1:0] e_wb;
    logic [2:0] e_m;
    logic [3:0] e_ex;
    logic       e_v;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [1:0] wb, input logic [2:0] m,
                              input logic [3:0] ex, input logic v,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic fl,
                              input logic e_stall, input logic [1:0] e_wb,
                              input logic [2:0] e_m, input logic [3:0] e_ex,
                              input logic e_v);
    vec_t r;
    r.wb = wb; r.m = m; r.ex = ex; r.v = v;
    r.rs = rs; r.rt = rt; r.rd = rd; r.fl = fl;
    r.e_stall = e_stall; r.e_wb = e_wb; r.e_m = e_m; r.e_ex = e_ex; r.e_v = e_v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Common instruction shapes: lw {wb=11,m=010,ex=0100}, R-type {10,000,1010}.
  task automatic fill_table();
    //            wb     m       ex      v     rs  rt  rd  fl    st    ewb    em      eex     ev
    vecs.push_back(mk(2'b00, 3'b000, 4'b0000, 1'b0, 0,  0,  0, 1'b0, 1'b0, 2'b00, 3'b000, 4'b0000, 1'b0)); // idle
    vecs.push_back(mk(2'b10, 3'b000, 4'b1010, 1'b1, 1,  2,  3, 1'b0, 1'b0, 2'b10, 3'b000, 4'b1010, 1'b1)); // R-type
    vecs.push_back(mk(2'b11, 3'b010, 4'b0100, 1'b1, 4,  8,  0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b0100, 1'b1)); // lw rt=8
    vecs.push_back(mk(2'b10, 3'b000, 4'b1010, 1'b1, 8,  9, 10, 1'b0, 1'b1, 2'b00, 3'b000, 4'b0000, 1'b0)); // use rs=8 -> bubble
    vecs.push_back(mk(2'b10, 3'b000, 4'b1010, 1'b1, 8,  9, 10, 1'b0, 1'b0, 2'b10, 3'b000, 4'b1010, 1'b1)); // held R-type enters
    vecs.push_back(mk(2'b11, 3'b010, 4'b0100, 1'b1, 4,  8,  0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b0100, 1'b1)); // lw rt=8
    vecs.push_back(mk(2'b10, 3'b000, 4'b0100, 1'b1, 4,  8, 11, 1'b0, 1'b0, 2'b10, 3'b000, 4'b0100, 1'b1)); // addi rt=8: no stall
    vecs.push_back(mk(2'b11, 3'b010, 4'b0100, 1'b1, 3,  0,  0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b0100, 1'b1)); // lw rt=0
    vecs.push_back(mk(2'b10, 3'b000, 4'b1010, 1'b1, 0,  0, 12, 1'b0, 1'b0, 2'b10, 3'b000, 4'b1010, 1'b1)); // use $zero: no stall
    vecs.push_back(mk(2'b11, 3'b010, 4'b0100, 1'b1, 4,  8,  0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b0100, 1'b1)); // lw rt=8
    vecs.push_back(mk(2'b00, 3'b001, 4'b0100, 1'b1, 5,  8,  0, 1'b0, 1'b1, 2'b00, 3'b000, 4'b0000, 1'b0)); // sw rt=8 -> bubble
    vecs.push_back(mk(2'b00, 3'b001, 4'b0100, 1'b1, 5,  8,  0, 1'b0, 1'b0, 2'b00, 3'b001, 4'b0100, 1'b1)); // sw enters
    vecs.push_back(mk(2'b11, 3'b010, 4'b0100, 1'b1, 4,  8,  0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b0100, 1'b1)); // lw rt=8
    vecs.push_back(mk(2'b10, 3'b000, 4'b1010, 1'b1, 8,  9, 10, 1'b1, 1'b0, 2'b00, 3'b000, 4'b0000, 1'b0)); // use + flush: flush wins
    vecs.push_back(mk(2'b11, 3'b010, 4'b0100, 1'b1, 4,  7,  0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b0100, 1'b1)); // lw rt=7
    vecs.push_back(mk(2'b00, 3'b100, 4'b0001, 1'b1, 1,  7,  0, 1'b0, 1'b1, 2'b00, 3'b000, 4'b0000, 1'b0)); // beq rt=7 -> bubble
    vecs.push_back(mk(2'b00, 3'b100, 4'b0001, 1'b1, 1,  7,  0, 1'b0, 1'b0, 2'b00, 3'b100, 4'b0001, 1'b1)); // beq enters
    vecs.push_back(mk(2'b10, 3'b000, 4'b1010, 1'b0, 1,  2,  3, 1'b0, 1'b0, 2'b10, 3'b000, 4'b1010, 1'b0)); // id_valid=0
    vecs.push_back(mk(2'b10, 3'b100, 4'b0001, 1'b1, 2,  3,  0, 1'b0, 1'b0, 2'b10, 3'b100, 4'b0001, 1'b1)); // branch w/ RegWrite passes
    vecs.push_back(mk(2'b11, 3'b010, 4'b0100, 1'b1, 4,  5,  0, 1'b1, 1'b0, 2'b00, 3'b000, 4'b0000, 1'b0)); // plain flush
    vecs.push_back(mk(2'b11, 3'b010, 4'b0100, 1'b1, 4,  6,  0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b0100, 1'b1)); // lw rt=6
    vecs.push_back(mk(2'b10, 3'b000, 4'b1010, 1'b0, 6,  1,  2, 1'b0, 1'b0, 2'b10, 3'b000, 4'b1010, 1'b0)); // invalid ID never stalls
    vecs.push_back(mk(2'b11, 3'b010, 4'b0100, 1'b1, 4,  6,  0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b0100, 1'b1)); // lw rt=6
    vecs.push_back(mk(2'b10, 3'b000, 4'b1010, 1'b1, 1,  6,  2, 1'b0, 1'b1, 2'b00, 3'b000, 4'b0000, 1'b0)); // R-type rt=6 -> bubble
    vecs.push_back(mk(2'b10, 3'b000, 4'b1010, 1'b1, 1,  6,  2, 1'b0, 1'b0, 2'b10, 3'b000, 4'b1010, 1'b1)); // R-type enters
  endtask

  task automatic drive(input vec_t t, input int idx);
    id_wb = t.wb; id_m = t.m; id_ex = t.ex; id_valid = t.v;
    id_rs = t.rs; id_rt = t.rt; id_rd = t.rd; flush = t.fl;
    id_pc4 = 32'h0040_0000 + 32'(idx) * 4;
    id_rd1 = 32'hA000_0000 | 32'(idx);
    id_rd2 = 32'hB000_0000 | 32'(idx);
    id_imm = 32'hFFFF_FF00 | 32'(idx);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fill_table();

    // Reset is asynchronous: outputs are cleared while it is held.
    #1;
    chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset ex_ctrl", {23'd0, ex_wb, ex_m, ex_ex}, 32'd0);
    chk("reset ex_rd1", ex_rd1, 32'd0);
    chk("reset stall/pc_write", {30'd0, stall, pc_write}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post-reset idle ctrl", {22'd0, ex_valid, ex_wb, ex_m, ex_ex}, 32'd0);
    chk("post-reset pc_write/if_id_write", {30'd0, pc_write, if_id_write}, 32'd3);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], i);
      n_vec++;
      @(negedge clk);
      chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d pc_write/if_id_write", i), {30'd0, pc_write, if_id_write},
          {30'd0, ~vecs[i].e_stall, ~vecs[i].e_stall});
      @(posedge clk); #1;
      chk($sformatf("v%0d ex_ctrl", i), {22'd0, ex_valid, ex_wb, ex_m, ex_ex},
          {22'd0, vecs[i].e_v, vecs[i].e_wb, vecs[i].e_m, vecs[i].e_ex});
      chk($sformatf("v%0d ex_regs", i), {17'd0, ex_rs, ex_rt, ex_rd},
          {17'd0, vecs[i].rs, vecs[i].rt, vecs[i].rd});
      chk($sformatf("v%0d ex_rd1", i), ex_rd1, 32'hA000_0000 | 32'(i));
      chk($sformatf("v%0d ex_rd2", i), ex_rd2, 32'hB000_0000 | 32'(i));
      chk($sformatf("v%0d ex_imm", i), ex_imm, 32'hFFFF_FF00 | 32'(i));
      chk($sformatf("v%0d ex_pc4", i), ex_pc4, 32'h0040_0000 + 32'(i) * 4);
    end

`ifdef ID_EX_PERF_CNT_EN
    // Bubbles at rows 3, 10, 15, 23; flushes at rows 13, 19.
    chk("bubble_cnt", bubble_cnt, 32'd4);
    chk("flush_cnt", flush_cnt, 32'd2);
`endif

    // Reset asserted in the middle of a stall cycle.
    drive(mk(2'b11, 3'b010, 4'b0100, 1'b1, 4, 8, 0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b0100, 1'b1), 40);
    n_vec++;
    @(posedge clk); #1;
    chk("midreset lw latched", {22'd0, ex_valid, ex_wb, ex_m, ex_ex}, {22'd0, 1'b1, 2'b11, 3'b010, 4'b0100});
    drive(mk(2'b10, 3'b000, 4'b1010, 1'b1, 8, 9, 10, 1'b0, 1'b1, 2'b00, 3'b000, 4'b0000, 1'b0), 41);
    n_vec++;
    @(negedge clk);
    chk("midreset stall before reset", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset ex_ctrl", {22'd0, ex_valid, ex_wb, ex_m, ex_ex}, 32'd0);
    chk("midreset stall/pc_write/if_id_write", {29'd0, stall, pc_write, if_id_write}, 32'd3);
    chk("midreset ex_rd1", ex_rd1, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("midreset counters", bubble_cnt | flush_cnt, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    // ex_valid was 0 after reset, so the R-type now enters without stalling.
    chk("post-midreset R-type", {22'd0, ex_valid, ex_wb, ex_m, ex_ex}, {22'd0, 1'b1, 2'b10, 3'b000, 4'b1010});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
